wb_commit_stage: RTL and testbench

Parametrised multi-lane writeback stage that sits after MEM2 and drives the register-file write ports. It captures LANES instruction slots per cycle into a flushable, stallable stage register and selects each lane's result internally from PC+8, ALU, OutB or DMOut. It resolves same-destination conflicts between lanes and suppresses writes while the data cache stalls the pipe. It guarantees each captured instruction commits exactly once, and counts retired instructions.

---
 rtl/wb_commit_stage_if.sv | 52 +++++
 rtl/wb_commit_stage.sv | 152 +++++++++++++++
 tb/tb_wb_commit_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_stage_if.sv
// Writeback stage bus: pipeline capture fields in, register-file write ports and retire count out.
// Optional difftest observation signals exist only when WB_DEBUG_EN is defined.
interface wb_commit_stage_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
);
  logic                    wb_flush;
  logic                    wb_wr;
  logic                    wb_diswr;
  logic [LANES-1:0]        in_valid;
  logic [LANES-1:0]        in_regwr;
  logic [LANES*PC_W-1:0]   in_pc;
  logic [LANES*2-1:0]      in_wbsel;
  logic [LANES*REG_W-1:0]  in_dst;
  logic [LANES*DATA_W-1:0] in_aluout;
  logic [LANES*DATA_W-1:0] in_outb;
  logic [LANES*DATA_W-1:0] in_dmout;

  logic [LANES-1:0]        rf_we;
  logic [LANES*REG_W-1:0]  rf_waddr;
  logic [LANES*DATA_W-1:0] rf_wdata;
  logic [LANES-1:0]        wb_valid;
  logic [LANES*PC_W-1:0]   wb_pc;
  logic [CNT_W-1:0]        retire_cnt;
`ifdef WB_DEBUG_EN
  logic [LANES-1:0]        dbg_commit_mask;
  logic [LANES*PC_W-1:0]   dbg_commit_pc;
`endif

  modport master (
    output wb_flush, wb_wr, wb_diswr,
    output in_valid, in_regwr, in_pc, in_wbsel, in_dst,
    output in_aluout, in_outb, in_dmout,
`ifdef WB_DEBUG_EN
    input  dbg_commit_mask, dbg_commit_pc,
`endif
    input  rf_we, rf_waddr, rf_wdata, wb_valid, wb_pc, retire_cnt
  );

  modport slave (
    input  wb_flush, wb_wr, wb_diswr,
    input  in_valid, in_regwr, in_pc, in_wbsel, in_dst,
    input  in_aluout, in_outb, in_dmout,
`ifdef WB_DEBUG_EN
    output dbg_commit_mask, dbg_commit_pc,
`endif
    output rf_we, rf_waddr, rf_wdata, wb_valid, wb_pc, retire_cnt
  );
endinterface

// File: rtl/wb_commit_stage.sv
// Multi-lane writeback stage: in_* captured at edge N, rf_* valid in cycle N+1; wb_diswr blocks commit
// combinationally, each captured bundle commits exactly once. WB_DEBUG_EN adds difftest commit outputs.
module wb_commit_stage #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input logic              clk,
  input logic              resetn,
  wb_commit_stage_if.slave bus
);
  localparam int XW = (PC_W > DATA_W) ? PC_W : DATA_W;

  typedef struct packed {
    logic              valid;
    logic              regwr;
    logic [PC_W-1:0]   pc;
    logic [1:0]        wbsel;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] outb;
    logic [DATA_W-1:0] dm;
  } lane_t;

  lane_t                   lane_q [LANES];
  lane_t                   lane_d [LANES];
  logic                    committed_q, committed_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    any_valid;
  logic                    commit_ok;
  logic [LANES-1:0]        valid_vec;
  logic [LANES-1:0]        shadowed;
  logic [LANES-1:0]        we_vec;
  logic [CNT_W-1:0]        pop;
  logic [XW-1:0]           pc8;
  logic [LANES*REG_W-1:0]  waddr_vec;
  logic [LANES*DATA_W-1:0] wdata_vec;
  logic [LANES*PC_W-1:0]   pc_vec;

  always_comb begin : capture
    any_valid   = 1'b0;
    committed_d = committed_q;
    for (int i = 0; i < LANES; i++) begin
      any_valid = any_valid | lane_q[i].valid;
      lane_d[i] = lane_q[i];
    end
    if (bus.wb_flush) begin
      for (int i = 0; i < LANES; i++) begin
        lane_d[i].valid = 1'b0;
        lane_d[i].regwr = 1'b0;
      end
      committed_d = 1'b0;
    end else if (bus.wb_wr) begin
      for (int i = 0; i < LANES; i++) begin
        lane_d[i].valid = bus.in_valid[i];
        lane_d[i].regwr = bus.in_regwr[i];
        lane_d[i].pc    = bus.in_pc[i*PC_W +: PC_W];
        lane_d[i].wbsel = bus.in_wbsel[i*2 +: 2];
        lane_d[i].dst   = bus.in_dst[i*REG_W +: REG_W];
        lane_d[i].alu   = bus.in_aluout[i*DATA_W +: DATA_W];
        lane_d[i].outb  = bus.in_outb[i*DATA_W +: DATA_W];
        lane_d[i].dm    = bus.in_dmout[i*DATA_W +: DATA_W];
      end
      committed_d = 1'b0;
    end else if (any_valid && !bus.wb_diswr) begin
      committed_d = 1'b1;
    end
  end

  always_comb begin : commit
    commit_ok = !bus.wb_diswr && !committed_q;
    pop       = '0;
    shadowed  = '0;
    valid_vec = '0;
    we_vec    = '0;
    for (int i = 0; i < LANES; i++) begin
      valid_vec[i] = lane_q[i].valid;
      pop          = pop + CNT_W'(lane_q[i].valid);
      // Youngest writer of a register wins; older lanes to the same dst are dropped.
      for (int j = i + 1; j < LANES; j++) begin
        if (lane_q[j].valid && lane_q[j].regwr && (lane_q[j].dst == lane_q[i].dst))
          shadowed[i] = 1'b1;
      end
      we_vec[i] = lane_q[i].valid && lane_q[i].regwr && commit_ok
                  && (lane_q[i].dst != '0) && !shadowed[i];
    end
    cnt_d = commit_ok ? (cnt_q + pop) : cnt_q;
  end

  always_comb begin : result_mux
    pc8       = '0;
    waddr_vec = '0;
    wdata_vec = '0;
    pc_vec    = '0;
    for (int i = 0; i < LANES; i++) begin
      pc8 = XW'(lane_q[i].pc) + XW'(8);
      waddr_vec[i*REG_W +: REG_W] = lane_q[i].dst;
      pc_vec[i*PC_W +: PC_W]      = lane_q[i].pc;
      case (lane_q[i].wbsel)
        2'd0:    wdata_vec[i*DATA_W +: DATA_W] = DATA_W'(pc8);
        2'd1:    wdata_vec[i*DATA_W +: DATA_W] = lane_q[i].alu;
        2'd2:    wdata_vec[i*DATA_W +: DATA_W] = lane_q[i].outb;
        default: wdata_vec[i*DATA_W +: DATA_W] = lane_q[i].dm;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i]       <= '0;
        // Reset selects the zeroed ALU field so rf_wdata reads 0 rather than pc+8.
        lane_q[i].wbsel <= 2'd1;
      end
      committed_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= lane_d[i];
      end
      committed_q <= committed_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.rf_we      = we_vec;
  assign bus.rf_waddr   = waddr_vec;
  assign bus.rf_wdata   = wdata_vec;
  assign bus.wb_valid   = valid_vec;
  assign bus.wb_pc      = pc_vec;
  assign bus.retire_cnt = cnt_q;

`ifdef WB_DEBUG_EN
  logic [LANES-1:0]      dbg_mask;
  logic [LANES*PC_W-1:0] dbg_pc;

  always_comb begin : debug_view
    dbg_mask = valid_vec & {LANES{commit_ok}};
    dbg_pc   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (dbg_mask[i])
        dbg_pc[i*PC_W +: PC_W] = lane_q[i].pc;
    end
  end

  assign bus.dbg_commit_mask = dbg_mask;
  assign bus.dbg_commit_pc   = dbg_pc;
`endif
endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed scenarios then random traffic against a rule-level reference model.
module tb_wb_commit_stage;
  localparam int L  = 2;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int RW = 5;
  localparam int CW = 32;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  wb_commit_stage_if #(.LANES(L), .DATA_W(DW), .PC_W(PW), .REG_W(RW), .CNT_W(CW)) bus ();

  wb_commit_stage #(.LANES(L), .DATA_W(DW), .PC_W(PW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the bundle currently in writeback plus whether it has already retired.
  bit          m_loaded, m_done;
  logic [CW-1:0] m_cnt;
  bit          m_valid [L];
  bit          m_regwr [L];
  logic [PW-1:0] m_pc  [L];
  logic [1:0]  m_sel   [L];
  logic [RW-1:0] m_dst [L];
  logic [DW-1:0] m_alu [L];
  logic [DW-1:0] m_outb[L];
  logic [DW-1:0] m_dm  [L];

  task automatic m_reset();
    m_loaded = 0; m_done = 0; m_cnt = '0;
    for (int i = 0; i < L; i++) begin
      m_valid[i] = 0; m_regwr[i] = 0; m_pc[i] = '0; m_sel[i] = '0;
      m_dst[i] = '0; m_alu[i] = '0; m_outb[i] = '0; m_dm[i] = '0;
    end
  endtask

  function automatic logic [DW-1:0] m_result(input int i);
    longint unsigned t;
    if (!m_loaded) return '0;
    case (m_sel[i])
      2'd0: begin
        t = longint'(m_pc[i]) + 64'd8;
        return DW'(t % (64'd1 << DW));
      end
      2'd1: return m_alu[i];
      2'd2: return m_outb[i];
      default: return m_dm[i];
    endcase
  endfunction

  task automatic settle();
    logic [L-1:0] ev, ewe;
    int owner [int];
    bit ok;
    #1;
    ok  = !bus.wb_diswr && !m_done;
    ev  = '0;
    ewe = '0;
    for (int i = 0; i < L; i++) begin
      ev[i] = m_valid[i];
      if (m_valid[i] && m_regwr[i]) owner[int'(m_dst[i])] = i;
    end
    for (int i = 0; i < L; i++)
      if (ok && m_valid[i] && m_regwr[i] && m_dst[i] != '0 && owner[int'(m_dst[i])] == i)
        ewe[i] = 1'b1;
    chk("wb_valid", 64'(bus.wb_valid), 64'(ev));
    chk("rf_we", 64'(bus.rf_we), 64'(ewe));
    chk("retire_cnt", 64'(bus.retire_cnt), 64'(m_cnt));
    for (int i = 0; i < L; i++) begin
      chk($sformatf("wb_pc%0d", i), 64'(bus.wb_pc[i*PW +: PW]), 64'(m_pc[i]));
      chk($sformatf("rf_waddr%0d", i), 64'(bus.rf_waddr[i*RW +: RW]), 64'(m_dst[i]));
      chk($sformatf("rf_wdata%0d", i), 64'(bus.rf_wdata[i*DW +: DW]), 64'(m_result(i)));
`ifdef WB_DEBUG_EN
      chk($sformatf("dbg_mask%0d", i), 64'(bus.dbg_commit_mask[i]), 64'(ok && m_valid[i]));
      chk($sformatf("dbg_pc%0d", i), 64'(bus.dbg_commit_pc[i*PW +: PW]),
          (ok && m_valid[i]) ? 64'(m_pc[i]) : 64'd0);
`endif
    end
  endtask

  task automatic advance();
    int n = 0;
    bit anyv = 0;
    for (int i = 0; i < L; i++) begin
      n += int'(m_valid[i]);
      anyv |= m_valid[i];
    end
    if (!bus.wb_diswr && !m_done) m_cnt = m_cnt + CW'(n);
    if (bus.wb_flush) begin
      for (int i = 0; i < L; i++) begin m_valid[i] = 0; m_regwr[i] = 0; end
      m_done = 0;
    end else if (bus.wb_wr) begin
      for (int i = 0; i < L; i++) begin
        m_valid[i] = bus.in_valid[i];
        m_regwr[i] = bus.in_regwr[i];
        m_pc[i]    = bus.in_pc[i*PW +: PW];
        m_sel[i]   = bus.in_wbsel[i*2 +: 2];
        m_dst[i]   = bus.in_dst[i*RW +: RW];
        m_alu[i]   = bus.in_aluout[i*DW +: DW];
        m_outb[i]  = bus.in_outb[i*DW +: DW];
        m_dm[i]    = bus.in_dmout[i*DW +: DW];
      end
      m_loaded = 1;
      m_done   = 0;
    end else if (anyv && !bus.wb_diswr) begin
      m_done = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit flush, input bit wr, input bit diswr);
    bus.wb_flush = flush;
    bus.wb_wr    = wr;
    bus.wb_diswr = diswr;
  endtask

  task automatic set_lane(input int i, input bit v, input bit rw, input logic [PW-1:0] pc,
                          input logic [1:0] sel, input logic [RW-1:0] dst,
                          input logic [DW-1:0] alu, input logic [DW-1:0] outb, input logic [DW-1:0] dm);
    bus.in_valid[i]            = v;
    bus.in_regwr[i]            = rw;
    bus.in_pc[i*PW +: PW]      = pc;
    bus.in_wbsel[i*2 +: 2]     = sel;
    bus.in_dst[i*RW +: RW]     = dst;
    bus.in_aluout[i*DW +: DW]  = alu;
    bus.in_outb[i*DW +: DW]    = outb;
    bus.in_dmout[i*DW +: DW]   = dm;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < L; i++) set_lane(i, 0, 0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    drive(0, 0, 0);
    clear_lanes();
    m_reset();
    @(negedge clk);
    settle();
    chk("rst_cnt", 64'(bus.retire_cnt), 64'd0);
    resetn = 1'b1;
    advance();

    // Single lane ALU write
    set_lane(0, 1, 1, 32'h100, 2'd1, 5'd3, 32'h1234, '0, '0);
    drive(0, 1, 0); settle(); advance();
    clear_lanes(); drive(0, 0, 0); settle();
    chk("tp1_we", 64'(bus.rf_we), 64'b01);
    chk("tp1_waddr0", 64'(bus.rf_waddr[RW-1:0]), 64'd3);
    chk("tp1_wdata0", 64'(bus.rf_wdata[DW-1:0]), 64'h1234);
    advance(); settle();
    chk("tp1_cnt", 64'(bus.retire_cnt), 64'd1);

    // Same destination on both lanes: younger lane wins
    set_lane(0, 1, 1, 32'h200, 2'd1, 5'd7, 32'hA, '0, '0);
    set_lane(1, 1, 1, 32'h204, 2'd1, 5'd7, 32'hB, '0, '0);
    drive(0, 1, 0); settle(); advance();
    clear_lanes(); drive(0, 0, 0); settle();
    chk("tp2_we", 64'(bus.rf_we), 64'b10);
    chk("tp2_wdata1", 64'(bus.rf_wdata[2*DW-1:DW]), 64'hB);
    advance(); settle();
    chk("tp2_cnt", 64'(bus.retire_cnt), 64'd3);

    // PC+8 link value, dst 0 suppressed but counted
    set_lane(0, 1, 1, 32'hBFC0_0000, 2'd0, 5'd0, '0, '0, '0);
    drive(0, 1, 0); settle(); advance();
    clear_lanes(); drive(0, 0, 0); settle();
    chk("tp3_wdata0", 64'(bus.rf_wdata[DW-1:0]), 64'hBFC0_0008);
    chk("tp3_we", 64'(bus.rf_we), 64'b00);
    advance(); settle();
    chk("tp3_cnt", 64'(bus.retire_cnt), 64'd4);

    // Stall for three cycles, release once, then hold
    set_lane(0, 1, 1, 32'h300, 2'd2, 5'd9, '0, 32'h55, '0);
    set_lane(1, 1, 1, 32'h304, 2'd3, 5'd10, '0, '0, 32'h66);
    drive(0, 1, 0); settle(); advance();
    clear_lanes();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1); settle();
      chk("stall_we", 64'(bus.rf_we), 64'b00);
      advance();
    end
    drive(0, 0, 0); settle();
    chk("release_we", 64'(bus.rf_we), 64'b11);
    advance(); settle();
    chk("hold_we", 64'(bus.rf_we), 64'b00);
    chk("hold_cnt", 64'(bus.retire_cnt), 64'd6);
    advance(); settle();
    chk("hold_cnt2", 64'(bus.retire_cnt), 64'd6);
    advance();

    // Flush beats load
    set_lane(0, 1, 1, 32'h400, 2'd1, 5'd1, 32'h11, '0, '0);
    set_lane(1, 1, 1, 32'h404, 2'd1, 5'd2, 32'h22, '0, '0);
    drive(1, 1, 0); settle(); advance();
    clear_lanes(); drive(0, 0, 0); settle();
    chk("flush_valid", 64'(bus.wb_valid), 64'b00);
    chk("flush_we", 64'(bus.rf_we), 64'b00);
    advance();

    // Reset during a stall clears everything immediately
    set_lane(0, 1, 1, 32'h500, 2'd1, 5'd4, 32'h77, '0, '0);
    drive(0, 1, 0); settle(); advance();
    clear_lanes(); drive(0, 0, 1); settle();
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.wb_valid), 64'd0);
    chk("arst_we", 64'(bus.rf_we), 64'd0);
    chk("arst_pc", 64'(bus.wb_pc), 64'd0);
    chk("arst_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("arst_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("arst_cnt", 64'(bus.retire_cnt), 64'd0);
    m_reset();
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, 0);
    settle(); advance();

    // Random traffic with frequent conflicts and stalls
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < L; i++)
        set_lane(i, 1'($urandom), 1'($urandom), $urandom, 2'($urandom),
                 RW'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      drive($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 9) < 4);
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
